match_referee: RTL and testbench
================================

MATCH_REFEREE -- requirements
Module: match_referee

Interface
REQ-001 SHALL have parameter TICKS_PER_ROUND, default 1000, meaning clk cycles per round before timeout (1..65535).
REQ-002 SHALL have parameter ROUNDS_TO_WIN, default 2, meaning round wins that end the match.
REQ-003 SHALL have parameter MAX_ROUNDS, default 5, meaning hard cap on rounds played, draws included.
REQ-004 SHALL have parameter END_HOLD, default 4, meaning clk cycles spent in ROUND_END (>=1).
REQ-005 SHALL have port clk  in  1  system clock, all logic on posedge; single clock domain.
REQ-006 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port start  in  1  level; starts a match from IDLE or MATCH_OVER.
REQ-008 SHALL have port health1  in  2  player-1 health from that player's module; 0 = knocked out.
REQ-009 SHALL have port health2  in  2  player-2 health; 0 = knocked out.
REQ-010 SHALL have port round_rst  out  1  one-cycle pulse commanding both player modules to restore health 3 and start position.
REQ-011 SHALL have port fight_en  out  1  high only in FIGHT; player modules ignore actions while low.
REQ-012 SHALL have port phase  out  2  current FSM state.
REQ-013 SHALL have port round_winner  out  2  winner of the last finished round: NONE/P1/P2/DRAW.
REQ-014 SHALL have ports score1 and score2  out  2 each  round wins per player.
REQ-015 SHALL have port round_no  out  3  rounds finished in this match.
REQ-016 SHALL have port time_left  out  16  remaining round ticks.
REQ-017 SHALL have port match_winner  out  2  NONE until MATCH_OVER, then P1/P2/DRAW.

Function
REQ-018 SHALL implement states IDLE, FIGHT, ROUND_END, MATCH_OVER.
REQ-019 IDLE/MATCH_OVER with start=1 SHALL go to FIGHT next cycle, clear scores, round_no, round_winner and match_winner, pulse round_rst in that same cycle, and load time_left=TICKS_PER_ROUND.
REQ-020 In FIGHT, health is sampled every cycle; health1==0 or health2==0 in cycle N SHALL enter ROUND_END at N+1, with round_winner, score and round_no updated at N+1.
REQ-021 Both healths 0 in the same cycle SHALL give DRAW, with no score change.
REQ-022 time_left SHALL decrement by 1 each FIGHT cycle and saturate at 0; reaching 0 without KO SHALL end the round: higher health wins, equal health gives DRAW.
REQ-023 KO and timeout in the same cycle SHALL be resolved as KO.
REQ-024 Score updates SHALL saturate at 3.
REQ-025 ROUND_END SHALL last exactly END_HOLD cycles, then go to MATCH_OVER if a score equals ROUNDS_TO_WIN or round_no equals MAX_ROUNDS; otherwise go to FIGHT with a round_rst pulse on the exit cycle and time_left reloaded.
REQ-026 At the cap, match_winner SHALL be the higher score, with equal scores giving DRAW.
REQ-027 start SHALL be ignored in FIGHT and ROUND_END.
REQ-028 Winner codes SHALL be NONE=00, P1=01, P2=10, DRAW=11.
REQ-029 Phase codes SHALL be IDLE=00, FIGHT=01, ROUND_END=10, MATCH_OVER=11.

Reset
REQ-030 rst_n low SHALL force IDLE, round_rst=0, fight_en=0, scores, round_no, round_winner and match_winner to 0, and time_left=TICKS_PER_ROUND, regardless of any in-progress match; the reset is asynchronous in assertion.
REQ-031 The first cycle after reset release SHALL behave as IDLE.

Configuration
REQ-032 With macro MATCH_ROUND_TIMER_EN defined, timeout behaviour (REQ-022) SHALL be active.
REQ-033 Without MATCH_ROUND_TIMER_EN, rounds SHALL end only by KO, time_left SHALL be held at 0, and no timer logic is synthesised.

Structure
REQ-034 Package game_pkg SHALL hold the phase and winner enums, the health width constant (2) and the max-health constant (3), shared with the player modules.
REQ-035 Sub-module round_timer (load, enable, count, expired) SHALL implement the tick counter and exist only under MATCH_ROUND_TIMER_EN.

Verification
REQ-036 Reset, then start=1 for 1 cycle -> next cycle phase=FIGHT, round_rst=1 for one cycle, time_left=1000.
REQ-037 In FIGHT with health2 driven to 0 at cycle N -> N+1 phase=ROUND_END, round_winner=P1, score1=1; after 4 cycles phase=FIGHT with a round_rst pulse.
REQ-038 health1=health2=0 in the same cycle -> round_winner=DRAW, scores unchanged, round_no+1.
REQ-039 TICKS_PER_ROUND=8 with health1=2 and health2=1 held -> after 8 FIGHT cycles round_winner=P1; with 1/1 -> DRAW; with macro undefined, no round end occurs.
REQ-040 P2 wins two KO rounds -> phase=MATCH_OVER, match_winner=P2; start=1 then clears scores and restarts.
REQ-041 rst_n asserted mid-ROUND_END -> immediately phase=IDLE and all outputs at reset values.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared phase/winner encodings and health constants for the referee and player modules
package game_pkg;
  localparam int HEALTH_W = 2;
  localparam logic [HEALTH_W-1:0] HEALTH_MAX = 2'd3;
  typedef enum logic [1:0] {IDLE = 2'b00, FIGHT = 2'b01, ROUND_END = 2'b10, MATCH_OVER = 2'b11} phase_t;
  typedef enum logic [1:0] {NONE = 2'b00, P1 = 2'b01, P2 = 2'b10, DRAW = 2'b11} winner_t;
  function automatic logic [1:0] sat_inc(input logic [1:0] s);
    return (s == 2'd3) ? s : s + 2'd1;
  endfunction
endpackage

// File: rtl/round_timer.sv
// round_timer: per-round tick counter, reloaded on load, counts down while enabled, saturating at 0
module round_timer #(
  parameter int TICKS = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        enable,
  output logic [15:0] count,
  output logic        expired
);
  localparam logic [15:0] TICKS16 = 16'(TICKS);
  // count register: reload wins, otherwise decrement while fighting
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= TICKS16;
    else if (load) count <= TICKS16;
    else if (enable && count != 16'd0) count <= count - 16'd1;
  // this cycle's decrement lands on zero, so the round times out at this edge
  assign expired = enable && (count <= 16'd1);
endmodule

// File: rtl/match_referee.sv
// match_referee: round/match referee FSM for a two-player fight; round timer enabled by MATCH_ROUND_TIMER_EN
module match_referee
  import game_pkg::*;
#(
  parameter int TICKS_PER_ROUND = 1000,
  parameter int ROUNDS_TO_WIN   = 2,
  parameter int MAX_ROUNDS      = 5,
  parameter int END_HOLD        = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [HEALTH_W-1:0] health1,
  input  logic [HEALTH_W-1:0] health2,
  output logic                round_rst,
  output logic                fight_en,
  output logic [1:0]          phase,
  output logic [1:0]          round_winner,
  output logic [1:0]          score1,
  output logic [1:0]          score2,
  output logic [2:0]          round_no,
  output logic [15:0]         time_left,
  output logic [1:0]          match_winner
);
  localparam int HW = (END_HOLD > 1) ? $clog2(END_HOLD) : 1;
  phase_t         state, state_n;
  winner_t        rw, rw_n, mw, mw_n, verdict;
  logic [1:0]     s1_n, s2_n;
  logic [2:0]     rno_n;
  logic [HW-1:0]  hold, hold_n;
  logic           rr_n, ko, expired, done;
  assign fight_en     = (state == FIGHT);
  assign phase        = state;
  assign round_winner = rw;
  assign match_winner = mw;
  assign ko      = (health1 == '0) || (health2 == '0);
  // KO bits map directly onto winner codes: only P2 down -> P1, only P1 down -> P2, both -> DRAW
  assign verdict = ko ? winner_t'({health1 == '0, health2 == '0}) :
                   (health1 > health2) ? P1 : (health1 < health2) ? P2 : DRAW;
  assign done    = (score1 == 2'(ROUNDS_TO_WIN)) || (score2 == 2'(ROUNDS_TO_WIN)) ||
                   (round_no == 3'(MAX_ROUNDS));
`ifdef MATCH_ROUND_TIMER_EN
  round_timer #(.TICKS(TICKS_PER_ROUND)) u_timer (
    .clk(clk), .rst_n(rst_n), .load(rr_n), .enable(fight_en), .count(time_left), .expired(expired)
  );
`else
  assign time_left = '0;
  assign expired   = 1'b0;
`endif
  // next-state and round/match bookkeeping
  always_comb begin
    state_n = state;
    hold_n  = hold;
    s1_n    = score1;
    s2_n    = score2;
    rno_n   = round_no;
    rw_n    = rw;
    mw_n    = mw;
    rr_n    = 1'b0;
    unique case (state)
      IDLE, MATCH_OVER: if (start) begin
        state_n = FIGHT;
        s1_n    = '0;
        s2_n    = '0;
        rno_n   = '0;
        rw_n    = NONE;
        mw_n    = NONE;
        rr_n    = 1'b1;
      end
      FIGHT: if (ko || expired) begin
        state_n = ROUND_END;
        hold_n  = HW'(END_HOLD - 1);
        rw_n    = verdict;
        s1_n    = (verdict == P1) ? sat_inc(score1) : score1;
        s2_n    = (verdict == P2) ? sat_inc(score2) : score2;
        rno_n   = round_no + 3'(round_no != 3'd7);
      end
      ROUND_END: if (hold == '0) begin
        state_n = done ? MATCH_OVER : FIGHT;
        rr_n    = !done;
        mw_n    = !done ? NONE : (score1 > score2) ? P1 : (score1 < score2) ? P2 : DRAW;
      end else hold_n = hold - 1'b1;
      default: state_n = IDLE;
    endcase
  end
  // state and scoreboard registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      hold      <= '0;
      score1    <= '0;
      score2    <= '0;
      round_no  <= '0;
      rw        <= NONE;
      mw        <= NONE;
      round_rst <= 1'b0;
    end else begin
      state     <= state_n;
      hold      <= hold_n;
      score1    <= s1_n;
      score2    <= s2_n;
      round_no  <= rno_n;
      rw        <= rw_n;
      mw        <= mw_n;
      round_rst <= rr_n;
    end
endmodule

// File: tb/tb_match_referee.sv
// tb_match_referee: directed pins plus randomized play checked every cycle against a behavioural referee model
module tb_match_referee;
`ifdef MATCH_ROUND_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif
  localparam int T = 1000, RTW = 2, MAXR = 5, HOLD = 4;
  localparam int TL0 = TIMER ? T : 0;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [1:0] health1 = 2'd3, health2 = 2'd3;
  logic round_rst, fight_en;
  logic [1:0] phase, round_winner, score1, score2, match_winner;
  logic [2:0] round_no;
  logic [15:0] time_left;
  int n_cmp = 0, n_bad = 0;

  match_referee #(.TICKS_PER_ROUND(T), .ROUNDS_TO_WIN(RTW), .MAX_ROUNDS(MAXR), .END_HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .health1(health1), .health2(health2),
    .round_rst(round_rst), .fight_en(fight_en), .phase(phase), .round_winner(round_winner),
    .score1(score1), .score2(score2), .round_no(round_no), .time_left(time_left),
    .match_winner(match_winner)
  );

  always #5 clk = ~clk;

  // reference model: phase 0 idle, 1 fight, 2 round end, 3 match over
  int m_phase, m_tl, m_s1, m_s2, m_rno, m_rw, m_mw, m_rr, m_left;

  task automatic m_reset();
    m_phase = 0; m_tl = TL0; m_s1 = 0; m_s2 = 0; m_rno = 0; m_rw = 0; m_mw = 0; m_rr = 0; m_left = 0;
  endtask

  task automatic m_step();
    int h1, h2, w;
    bit timeout;
    h1 = int'(health1);
    h2 = int'(health2);
    m_rr = 0;
    case (m_phase)
      0, 3: if (start) begin
        m_phase = 1; m_s1 = 0; m_s2 = 0; m_rno = 0; m_rw = 0; m_mw = 0; m_rr = 1; m_tl = TL0;
      end
      1: begin
        timeout = 1'b0;
        if (TIMER) begin
          m_tl = (m_tl > 0) ? m_tl - 1 : 0;
          timeout = (m_tl == 0);
        end
        if (h1 == 0 && h2 == 0) w = 3;
        else if (h1 == 0) w = 2;
        else if (h2 == 0) w = 1;
        else if (timeout) w = (h1 > h2) ? 1 : (h1 < h2) ? 2 : 3;
        else w = 0;
        if (w != 0) begin
          m_phase = 2;
          m_left = HOLD;
          m_rw = w;
          if (w == 1 && m_s1 < 3) m_s1++;
          if (w == 2 && m_s2 < 3) m_s2++;
          if (m_rno < 7) m_rno++;
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          if (m_s1 == RTW || m_s2 == RTW || m_rno == MAXR) begin
            m_phase = 3;
            m_mw = (m_s1 > m_s2) ? 1 : (m_s1 < m_s2) ? 2 : 3;
          end else begin
            m_phase = 1; m_rr = 1; m_tl = TL0;
          end
        end
      end
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge rst_n) m_reset();

  // model advance on each edge, then compare every output just after the edge
  always @(posedge clk) begin
    if (!rst_n) m_reset();
    else m_step();
    #1;
    chk("phase", 32'(phase), m_phase);
    chk("fight_en", 32'(fight_en), 32'(m_phase == 1));
    chk("round_rst", 32'(round_rst), m_rr);
    chk("round_winner", 32'(round_winner), m_rw);
    chk("score1", 32'(score1), m_s1);
    chk("score2", 32'(score2), m_s2);
    chk("round_no", 32'(round_no), m_rno);
    chk("time_left", 32'(time_left), m_tl);
    chk("match_winner", 32'(match_winner), m_mw);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int calm;
    cyc(3);
    chk("rst_phase", 32'(phase), 0);
    chk("rst_time_left", 32'(time_left), TL0);
    chk("rst_round_rst", 32'(round_rst), 0);
    rst_n = 1'b1;
    cyc(1);
    chk("idle_after_release", 32'(phase), 0);
    start = 1'b1; cyc(1); start = 1'b0;
    chk("start_phase", 32'(phase), 1);
    chk("start_round_rst", 32'(round_rst), 1);
    chk("start_time_left", 32'(time_left), TL0);
    cyc(1);
    chk("round_rst_one_cycle", 32'(round_rst), 0);
    chk("time_dec", 32'(time_left), TIMER ? T - 1 : 0);
    health2 = 2'd0; cyc(1); health2 = 2'd3;
    chk("ko_phase", 32'(phase), 2);
    chk("ko_winner_p1", 32'(round_winner), 1);
    chk("ko_score1", 32'(score1), 1);
    cyc(3);
    chk("hold_still_end", 32'(phase), 2);
    cyc(1);
    chk("hold_exit_fight", 32'(phase), 1);
    chk("hold_exit_rr", 32'(round_rst), 1);
    health1 = 2'd0; health2 = 2'd0; cyc(1); health1 = 2'd3; health2 = 2'd3;
    chk("draw_winner", 32'(round_winner), 3);
    chk("draw_score1", 32'(score1), 1);
    chk("draw_score2", 32'(score2), 0);
    chk("draw_round_no", 32'(round_no), 2);
    cyc(4);
    health1 = 2'd0; cyc(1); health1 = 2'd3;
    chk("p2_win1", 32'(score2), 1);
    cyc(4);
    health1 = 2'd0; cyc(1); health1 = 2'd3;
    chk("p2_win2", 32'(score2), 2);
    cyc(4);
    chk("match_over_phase", 32'(phase), 3);
    chk("match_winner_p2", 32'(match_winner), 2);
    start = 1'b1; cyc(1); start = 1'b0;
    chk("restart_phase", 32'(phase), 1);
    chk("restart_scores", 32'({score1, score2}), 0);
    chk("restart_mw", 32'(match_winner), 0);
    health1 = 2'd2; health2 = 2'd1;
    if (TIMER) begin
      cyc(T - 1);
      chk("timeout_not_yet", 32'(phase), 1);
      cyc(1);
      chk("timeout_phase", 32'(phase), 2);
      chk("timeout_winner_p1", 32'(round_winner), 1);
      cyc(4);
      health1 = 2'd1; health2 = 2'd1;
      cyc(T);
      chk("timeout_draw", 32'(round_winner), 3);
      cyc(4);
    end else begin
      cyc(T + 100);
      chk("no_timer_still_fight", 32'(phase), 1);
    end
    health1 = 2'd3; health2 = 2'd0; cyc(1); health2 = 2'd3;
    cyc(1);
    chk("pre_reset_end", 32'(phase), 2);
    #3 rst_n = 1'b0;
    #1;
    chk("async_phase", 32'(phase), 0);
    chk("async_scores", 32'({score1, score2, round_no}), 0);
    chk("async_winners", 32'({round_winner, match_winner}), 0);
    chk("async_fight_en", 32'(fight_en), 0);
    chk("async_time_left", 32'(time_left), TL0);
    cyc(2);
    rst_n = 1'b1;
    calm = 0;
    for (int i = 0; i < 15000; i++) begin
      start = ($urandom_range(7) == 0);
      if (calm > 0) begin
        calm--;
        health1 = 2'($urandom_range(3, 1));
        health2 = 2'($urandom_range(3, 1));
      end else begin
        if ($urandom_range(499) == 0) calm = T + 100;
        health1 = ($urandom_range(15) == 0) ? 2'd0 : 2'($urandom_range(3, 1));
        health2 = ($urandom_range(15) == 0) ? 2'd0 : 2'($urandom_range(3, 1));
      end
      if ($urandom_range(2999) == 0) begin
        rst_n = 1'b0; cyc(1); rst_n = 1'b1;
      end
      cyc(1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
